// File: rtl/mux4_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter_if
// Description : Request/grant/select bundle between four requesters and the
//               round-robin arbiter that steers the shared 4x1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
interface mux4_rr_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic       S0;
  logic       S1;
  logic       valid;

  // Requester side: raises requests, observes grant and mux selects.
  modport master (
    output req,
    input  gnt,
    input  S0,
    input  S1,
    input  valid
  );

  // Arbiter side.
  modport slave (
    input  req,
    output gnt,
    output S0,
    output S1,
    output valid
  );
endinterface
`default_nettype wire

// File: rtl/mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mux4_rr_arbiter
// Description : Round-robin arbiter with bounded hold time that grants one of
//               four requesters and drives the shared mux selects.
// Revision    : 1.0 - initial release
// ============================================================================
module mux4_rr_arbiter #(
  parameter int HOLD_MAX = 4
) (
  input  wire                     clk,
  input  wire                     rst_n,
  mux4_rr_arbiter_if.slave        bus
);

  localparam logic [3:0] c_hold_max = 4'(HOLD_MAX);
  localparam logic [3:0] c_cnt_one  = 4'd1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [1:0] r_owner;
  logic [3:0] r_cnt;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;

  logic       w_hold;
  logic       w_any;
  logic [1:0] w_ptr_eff;
  logic [1:0] w_idx;
  logic [1:0] w_pick;
  logic       w_found;

  assign w_any  = |bus.req;
  assign w_hold = (r_state == ST_GRANT) && bus.req[r_owner] && (r_cnt < c_hold_max);

  // On release the pointer moves past the outgoing owner, and the same-cycle
  // arbitration must already see that moved pointer.
  assign w_ptr_eff = (r_state == ST_GRANT) ? (r_owner + 2'd1) : r_ptr;

  always_comb begin
    w_idx   = w_ptr_eff;
    w_pick  = w_ptr_eff;
    w_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w_idx = w_ptr_eff + 2'(i);
      if (!w_found && bus.req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_owner <= 2'd0;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'b00;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_GRANT;
            r_owner <= w_pick;
            r_cnt   <= c_cnt_one;
            r_gnt   <= 4'b0001 << w_pick;
            r_sel   <= w_pick;
            r_valid <= 1'b1;
          end
        end
        ST_GRANT: begin
          if (w_hold) begin
            r_cnt <= r_cnt + 4'd1;
          end else begin
            r_ptr <= w_ptr_eff;
            if (w_any) begin
              r_owner <= w_pick;
              r_cnt   <= c_cnt_one;
              r_gnt   <= 4'b0001 << w_pick;
              r_sel   <= w_pick;
              r_valid <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_cnt   <= 4'd0;
              r_gnt   <= 4'b0000;
              r_sel   <= 2'b00;
              r_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= 4'b0000;
          r_sel   <= 2'b00;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.S1    = r_sel[1];
  assign bus.S0    = r_sel[0];
  assign bus.valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_mux4_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux4_rr_arbiter
// Description : Table-driven directed vectors plus randomized traffic checked
//               against a behavioural round-robin model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux4_rr_arbiter;

  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst_n;

  mux4_rr_arbiter_if bus ();

  mux4_rr_arbiter #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rstn;
    logic [3:0] req;
    logic [3:0] gnt;
    string      name;
  } vec_t;

  vec_t vecs[$];

  int checks   = 0;
  int failures = 0;

  // Behavioural model: who owns the mux, for how long, and who is searched first.
  bit m_busy;
  int m_owner;
  int m_cnt;
  int m_ptr;

  function automatic int first_from(int start, logic [3:0] r);
    for (int k = 0; k < 4; k++)
      if (r[(start + k) % 4]) return (start + k) % 4;
    return -1;
  endfunction

  task automatic model_edge(input logic rstn_v, input logic [3:0] r);
    if (!rstn_v) begin
      m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;
    end else if (!m_busy) begin
      if (r != 4'b0000) begin
        m_busy = 1; m_owner = first_from(m_ptr, r); m_cnt = 1;
      end
    end else if (r[m_owner] && m_cnt < HOLD_MAX) begin
      m_cnt = m_cnt + 1;
    end else begin
      m_ptr = (m_owner + 1) % 4;
      if (r != 4'b0000) begin
        m_owner = first_from(m_ptr, r); m_cnt = 1;
      end else begin
        m_busy = 0; m_cnt = 0;
      end
    end
  endtask

  function automatic logic [1:0] idx_of(logic [3:0] g);
    case (g)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic compare(input string name, input logic [3:0] eg);
    logic [1:0] es;
    logic       ev;
    es = idx_of(eg);
    ev = (eg != 4'b0000);
    checks++;
    if (bus.gnt !== eg || {bus.S1, bus.S0} !== es || bus.valid !== ev) begin
      failures++;
      $display("FAIL %s t=%0t got gnt=%b sel=%b valid=%b exp gnt=%b sel=%b valid=%b",
               name, $time, bus.gnt, {bus.S1, bus.S0}, bus.valid, eg, es, ev);
    end
  endtask

  // Called at a negedge: drive, clock, sample #1 later, return at next negedge.
  task automatic step(input logic rstn_v, input logic [3:0] r,
                      input bit use_model, input logic [3:0] eg, input string name);
    rst_n   = rstn_v;
    bus.req = r;
    @(posedge clk);
    #1;
    model_edge(rstn_v, r);
    if (use_model) compare(name, m_busy ? (4'b0001 << m_owner) : 4'b0000);
    else           compare(name, eg);
    @(negedge clk);
  endtask

  task automatic add(input logic rstn_v, input logic [3:0] r, input logic [3:0] g,
                     input string name);
    vec_t v;
    v.rstn = rstn_v; v.req = r; v.gnt = g; v.name = name;
    vecs.push_back(v);
  endtask

  initial begin
    logic [3:0] fl_seq [4];
    logic [3:0] rr;
    fl_seq[0] = 4'b0001; fl_seq[1] = 4'b0010; fl_seq[2] = 4'b0100; fl_seq[3] = 4'b1000;

    rst_n   = 1'b0;
    bus.req = 4'b0000;
    m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = 0;

    // Reset held with all requesting.
    for (int i = 0; i < 3; i++) add(1'b0, 4'b1111, 4'b0000, "reset_hold");
    // Single requester C, dropped after two cycles.
    add(1'b1, 4'b0100, 4'b0100, "single_c");
    add(1'b1, 4'b0100, 4'b0100, "single_c");
    add(1'b1, 4'b0000, 4'b0000, "single_drop");
    // Full load after a fresh reset: four cycles per owner, no bubble.
    add(1'b0, 4'b0000, 4'b0000, "reset");
    for (int i = 0; i < 20; i++) add(1'b1, 4'b1111, fl_seq[(i / 4) % 4], "full_load");
    // Early release by A hands straight to B; C never appears.
    add(1'b0, 4'b0000, 4'b0000, "reset");
    add(1'b1, 4'b1011, 4'b0001, "early_a");
    add(1'b1, 4'b1011, 4'b0001, "early_a");
    for (int i = 0; i < 4; i++) add(1'b1, 4'b1010, 4'b0010, "early_b");
    add(1'b1, 4'b1010, 4'b1000, "early_d");
    add(1'b1, 4'b1010, 4'b1000, "early_d");
    // Lone requester D expires repeatedly but is regranted without a gap.
    add(1'b0, 4'b0000, 4'b0000, "reset");
    for (int i = 0; i < 10; i++) add(1'b1, 4'b1000, 4'b1000, "lone_expiry");
    // Reset mid-hold restarts the pointer at A.
    add(1'b0, 4'b0000, 4'b0000, "reset");
    add(1'b1, 4'b0010, 4'b0010, "mid_b");
    add(1'b1, 4'b0010, 4'b0010, "mid_b");
    add(1'b0, 4'b1111, 4'b0000, "mid_reset");
    add(1'b1, 4'b1111, 4'b0001, "after_reset_a");

    @(negedge clk);
    foreach (vecs[i]) step(vecs[i].rstn, vecs[i].req, 1'b0, vecs[i].gnt, vecs[i].name);

    // Glitch between edges must not matter: toggle req away from the edge.
    step(1'b0, 4'b0000, 1'b1, 4'b0000, "glitch_reset");
    bus.req = 4'b0100;
    #2 bus.req = 4'b0000;
    step(1'b1, 4'b0000, 1'b1, 4'b0000, "glitch");

    // Randomized traffic, biased toward sticky requests, with rare resets.
    rr = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rr = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 59) != 0), rr, 1'b1, 4'b0000, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
